// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared FSM state and forwarding-select encodings for hazard_ctrl
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LDU   = 2'd1;
    localparam logic [1:0] ST_MWAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - combinational ALU operand forwarding select for one source register
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] ex_reg_dst,
    input  logic                  ex_reg_wr_en,
    input  logic                  ex_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] mem_reg_dst,
    input  logic                  mem_reg_wr_en,
    output logic [1:0]            sel
);

    // A load in EX has no result yet; the load-use bubble covers it, so skip to MEM.
    always_comb begin
        sel = FWD_REG;
        if (rs != '0) begin
            if (ex_reg_wr_en && !ex_mem_to_reg && (ex_reg_dst == rs)) begin
                sel = FWD_EXMEM;
            end else if (mem_reg_wr_en && (mem_reg_dst == rs)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I pipeline hazard controller: stalls, bubbles, flushes, forwarding selects
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FLUSH_LEN  = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] i_id_Rs1,
    input  logic [REG_ADDR_W-1:0] i_id_Rs2,
    input  logic                  i_id_UseRs1,
    input  logic                  i_id_UseRs2,
    input  logic [REG_ADDR_W-1:0] i_ex_RegDst,
    input  logic                  i_ex_RegWrEn,
    input  logic                  i_ex_MemToReg,
    input  logic [REG_ADDR_W-1:0] i_mem_RegDst,
    input  logic                  i_mem_RegWrEn,
    input  logic                  i_ex_Redirect,
    input  logic                  i_mem_Req,
    input  logic                  i_mem_Ready,
    output logic                  o_stall_if,
    output logic                  o_stall_id,
    output logic                  o_stall_ex,
    output logic                  o_stall_mem,
    output logic                  o_flush_id,
    output logic                  o_bubble_ex,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic [1:0]            o_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     o_cnt_ldu,
    output logic [PERF_W-1:0]     o_cnt_mwait,
    output logic [PERF_W-1:0]     o_cnt_flush
`endif
);

    logic [1:0] state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;
    logic       ldu, memw, in_flush, flush_last, redir_act, ldu_act;

    assign memw = i_mem_Req & ~i_mem_Ready;
    assign ldu  = i_ex_MemToReg & i_ex_RegWrEn & (i_ex_RegDst != '0) &
                  ((i_id_UseRs1 & (i_id_Rs1 == i_ex_RegDst)) |
                   (i_id_UseRs2 & (i_id_Rs2 == i_ex_RegDst)));

    assign in_flush   = (state == ST_FLUSH);
    assign flush_last = (({1'b0, flush_cnt} + 4'd1) == 4'(FLUSH_LEN));

    // EX holds a NOP while flushing or right after a load-use bubble, so its hazards are stale there.
    assign redir_act = i_ex_Redirect & ~in_flush;
    assign ldu_act   = ldu & ~i_ex_Redirect & ((state == ST_RUN) | (state == ST_MWAIT));

    assign o_stall_ex  = reset & memw;
    assign o_stall_mem = reset & memw;
    assign o_stall_if  = reset & (memw | ldu_act);
    assign o_stall_id  = reset & (memw | ldu_act);
    assign o_flush_id  = reset & ~memw & (redir_act | in_flush);
    assign o_bubble_ex = reset & ~memw & (redir_act | ldu_act);
    assign o_state     = state;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (memw) begin
            if (!in_flush) begin
                state_nxt = ST_MWAIT;
            end
        end else if (in_flush) begin
            if (flush_last) begin
                state_nxt     = ST_RUN;
                flush_cnt_nxt = 3'd0;
            end else begin
                flush_cnt_nxt = flush_cnt + 3'd1;
            end
        end else if (i_ex_Redirect) begin
            state_nxt     = (FLUSH_LEN > 0) ? ST_FLUSH : ST_RUN;
            flush_cnt_nxt = 3'd0;
        end else if (ldu_act) begin
            state_nxt = ST_LDU;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs            (i_id_Rs1),
        .ex_reg_dst    (i_ex_RegDst),
        .ex_reg_wr_en  (i_ex_RegWrEn),
        .ex_mem_to_reg (i_ex_MemToReg),
        .mem_reg_dst   (i_mem_RegDst),
        .mem_reg_wr_en (i_mem_RegWrEn),
        .sel           (fwd_a_nxt)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs            (i_id_Rs2),
        .ex_reg_dst    (i_ex_RegDst),
        .ex_reg_wr_en  (i_ex_RegWrEn),
        .ex_mem_to_reg (i_ex_MemToReg),
        .mem_reg_dst   (i_mem_RegDst),
        .mem_reg_wr_en (i_mem_RegWrEn),
        .sel           (fwd_b_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
            o_fwd_a   <= FWD_REG;
            o_fwd_b   <= FWD_REG;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (!memw) begin
                o_fwd_a <= (redir_act | ldu_act) ? FWD_REG : fwd_a_nxt;
                o_fwd_b <= (redir_act | ldu_act) ? FWD_REG : fwd_b_nxt;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_cnt_ldu   <= '0;
            o_cnt_mwait <= '0;
            o_cnt_flush <= '0;
        end else begin
            if (ldu_act && !memw && (o_cnt_ldu != '1)) begin
                o_cnt_ldu <= o_cnt_ldu + 1'b1;
            end
            if (memw && (o_cnt_mwait != '1)) begin
                o_cnt_mwait <= o_cnt_mwait + 1'b1;
            end
            if ((redir_act | in_flush) && !memw && (o_cnt_flush != '1)) begin
                o_cnt_flush <= o_cnt_flush + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (vector table, corner sequences, random vs model)
module tb_hazard_ctrl;

    localparam int W  = 5;
    localparam int FL = 2;

    typedef struct {
        logic [W-1:0] rs1, rs2;
        logic         u1, u2;
        logic [W-1:0] exd;
        logic         exw, exl;
        logic [W-1:0] memd;
        logic         memwe, redir, req, rdy;
        logic [11:0]  exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] i_id_Rs1, i_id_Rs2, i_ex_RegDst, i_mem_RegDst;
    logic         i_id_UseRs1, i_id_UseRs2, i_ex_RegWrEn, i_ex_MemToReg;
    logic         i_mem_RegWrEn, i_ex_Redirect, i_mem_Req, i_mem_Ready;
    logic         o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_bubble_ex;
    logic [1:0]   o_fwd_a, o_fwd_b, o_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]  o_cnt_ldu, o_cnt_mwait, o_cnt_flush;
`endif

    hazard_ctrl #(.REG_ADDR_W(W), .FLUSH_LEN(FL)) dut (
        .clk(clk), .reset(reset),
        .i_id_Rs1(i_id_Rs1), .i_id_Rs2(i_id_Rs2),
        .i_id_UseRs1(i_id_UseRs1), .i_id_UseRs2(i_id_UseRs2),
        .i_ex_RegDst(i_ex_RegDst), .i_ex_RegWrEn(i_ex_RegWrEn), .i_ex_MemToReg(i_ex_MemToReg),
        .i_mem_RegDst(i_mem_RegDst), .i_mem_RegWrEn(i_mem_RegWrEn),
        .i_ex_Redirect(i_ex_Redirect), .i_mem_Req(i_mem_Req), .i_mem_Ready(i_mem_Ready),
        .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_stall_ex(o_stall_ex),
        .o_stall_mem(o_stall_mem), .o_flush_id(o_flush_id), .o_bubble_ex(o_bubble_ex),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_state(o_state)
`ifdef HAZARD_PERF_CNT_EN
        , .o_cnt_ldu(o_cnt_ldu), .o_cnt_mwait(o_cnt_mwait), .o_cnt_flush(o_cnt_flush)
`endif
    );

    always #5 clk = ~clk;

    wire [11:0] act_w = {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem, o_flush_id, o_bubble_ex,
                         o_fwd_a, o_fwd_b, o_state};

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    // Reference model: pending flush cycles, whether last cycle was a load-use bubble or a memory freeze.
    int         m_flush_left;
    bit         m_prev_ldu, m_last_memw;
    logic [1:0] m_fa, m_fb;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rs1, rs2, u1, u2, exd, exw, exl, memd, memwe,
                                input int redir, req, rdy, input logic [11:0] exp);
        vec_t v;
        v.rs1 = W'(rs1); v.rs2 = W'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
        v.exd = W'(exd); v.exw = 1'(exw); v.exl = 1'(exl);
        v.memd = W'(memd); v.memwe = 1'(memwe);
        v.redir = 1'(redir); v.req = 1'(req); v.rdy = 1'(rdy);
        v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        i_id_Rs1 = v.rs1; i_id_Rs2 = v.rs2; i_id_UseRs1 = v.u1; i_id_UseRs2 = v.u2;
        i_ex_RegDst = v.exd; i_ex_RegWrEn = v.exw; i_ex_MemToReg = v.exl;
        i_mem_RegDst = v.memd; i_mem_RegWrEn = v.memwe;
        i_ex_Redirect = v.redir; i_mem_Req = v.req; i_mem_Ready = v.rdy;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [W-1:0] rs);
        if (rs == 0) return 2'd0;
        if (i_ex_RegWrEn && !i_ex_MemToReg && i_ex_RegDst == rs) return 2'd1;
        if (i_mem_RegWrEn && i_mem_RegDst == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_flush_left = 0; m_prev_ldu = 0; m_last_memw = 0; m_fa = 0; m_fb = 0;
    endtask

    task automatic model_cycle(output logic [11:0] exp);
        bit memw, flushing, ldu, redir, ldua, stall_f, flush, bub;
        logic [1:0] st;
        memw     = i_mem_Req && !i_mem_Ready;
        flushing = m_flush_left > 0;
        ldu      = i_ex_MemToReg && i_ex_RegWrEn && i_ex_RegDst != 0 &&
                   ((i_id_UseRs1 && i_id_Rs1 == i_ex_RegDst) || (i_id_UseRs2 && i_id_Rs2 == i_ex_RegDst));
        redir    = i_ex_Redirect && !flushing && !memw;
        ldua     = ldu && !i_ex_Redirect && !flushing && !m_prev_ldu && !memw;
        stall_f  = memw || ldua;
        flush    = !memw && (redir || flushing);
        bub      = redir || ldua;
        st       = flushing ? 2'd3 : m_last_memw ? 2'd2 : m_prev_ldu ? 2'd1 : 2'd0;
        exp = {stall_f, stall_f, memw, memw, flush, bub, m_fa, m_fb, st};
        if (memw) begin
            m_prev_ldu  = 0;
            m_last_memw = 1;
        end else begin
            m_fa = bub ? 2'd0 : ref_fwd(i_id_Rs1);
            m_fb = bub ? 2'd0 : ref_fwd(i_id_Rs2);
            if (flushing) m_flush_left--;
            else if (redir) m_flush_left = FL;
            m_prev_ldu  = ldua;
            m_last_memw = 0;
        end
    endtask

    initial begin
        logic [11:0] exp;
        vec_t idle, v;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0, 12'd0);

        //          rs1 rs2 u1 u2 exd exw exl md mwe rd rq ry   stalls/fl/bub fa   fb   st
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000000, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(5,0,1,0, 5,1,1, 0,0, 0,0,0, {6'b110001, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(5,0,1,0, 0,0,0, 5,1, 0,0,0, {6'b000000, 2'd0, 2'd0, 2'd1}));
        tbl.push_back(mk(0,3,0,1, 3,1,0, 0,0, 0,0,0, {6'b000000, 2'd2, 2'd0, 2'd0}));
        tbl.push_back(mk(0,0,0,1, 0,1,0, 0,0, 0,0,0, {6'b000000, 2'd0, 2'd1, 2'd0}));
        tbl.push_back(mk(0,3,0,1, 3,1,0, 0,0, 0,1,0, {6'b111100, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(0,3,0,1, 3,1,0, 0,0, 0,1,0, {6'b111100, 2'd0, 2'd0, 2'd2}));
        tbl.push_back(mk(0,3,0,1, 3,1,0, 0,0, 0,1,0, {6'b111100, 2'd0, 2'd0, 2'd2}));
        tbl.push_back(mk(0,3,0,1, 3,1,0, 0,0, 0,1,1, {6'b000000, 2'd0, 2'd0, 2'd2}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,0,0, {6'b000011, 2'd0, 2'd1, 2'd0}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000000, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(5,0,1,0, 5,1,1, 0,0, 1,0,0, {6'b000011, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000000, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,1,0, {6'b111100, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,1,0, {6'b111100, 2'd0, 2'd0, 2'd2}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,1,1, {6'b000011, 2'd0, 2'd0, 2'd2}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000000, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 1,0,0, {6'b000011, 2'd0, 2'd0, 2'd0}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,1,0, {6'b111100, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,1,1, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000010, 2'd0, 2'd0, 2'd3}));
        tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0,0,0, {6'b000000, 2'd0, 2'd0, 2'd0}));

        reset = 1'b0;
        drive(idle);
        @(negedge clk);
        check("reset_state", act_w, 12'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), act_w, tbl[i].exp);
        end

        // Load a forwarding select, then freeze on memory and reset in the middle of the wait.
        @(posedge clk); #1;
        drive(mk(3,0,1,0, 3,1,0, 0,0, 0,0,0, 12'd0));
        @(posedge clk); #1;
        drive(mk(0,0,0,0, 0,0,0, 0,0, 0,1,0, 12'd0));
        @(negedge clk);
        check("mwait_enter", act_w, {6'b111100, 2'd1, 2'd0, 2'd0});
        @(posedge clk); #1;
        @(negedge clk);
        check("mwait_hold", act_w, {6'b111100, 2'd1, 2'd0, 2'd2});
        #2 reset = 1'b0;
        #1 check("reset_mid_mwait", act_w, 12'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_clear", {11'd0, |{o_cnt_ldu, o_cnt_mwait, o_cnt_flush}}, 12'd0);
`endif
        @(posedge clk); #1;
        drive(idle);
        reset = 1'b1;
        model_reset();

        repeat (600) begin
            @(posedge clk); #1;
            v.rs1   = W'($urandom_range(0, 3));
            v.rs2   = W'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.exd   = W'($urandom_range(0, 3));
            v.exw   = 1'($urandom_range(0, 3) != 0);
            v.exl   = 1'($urandom_range(0, 2) == 0);
            v.memd  = W'($urandom_range(0, 3));
            v.memwe = 1'($urandom_range(0, 1));
            v.redir = 1'($urandom_range(0, 7) == 0);
            v.req   = 1'($urandom_range(0, 2) == 0);
            v.rdy   = 1'($urandom_range(0, 1));
            v.exp   = 12'd0;
            drive(v);
            @(negedge clk);
            model_cycle(exp);
            check("random", act_w, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
